// File: rtl/dff_drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dff_drive_pkg
//  Purpose  : Shared types and constants for the NAND D flip-flop driver
//             sequencer: request opcodes, sequencer states, error counter
//             width and a small max helper used to size the phase counter.
//  Revision : 1.0 - initial release
// ============================================================================
package dff_drive_pkg;

    localparam int c_err_cnt_w = 8;

    typedef enum logic [1:0] {
        OP_CAPTURE = 2'd0,
        OP_PRESET  = 2'd1,
        OP_CLEAR   = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_PULSE  = 3'd4,
        ST_SETTLE = 3'd5,
        ST_CHECK  = 3'd6,
        ST_RESP   = 3'd7
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module   : sync2
//  Purpose  : Two-flop synchroniser bringing an asynchronous flip-flop
//             output into the ck domain. Resets to 0.
//  Ports    : ck    - system clock
//             rst_n - asynchronous active-low reset
//             din   - asynchronous input
//             dout  - synchronised output
//  Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic ck,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic r_meta;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            dout   <= 1'b0;
        end else begin
            r_meta <= din;
            dout   <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_drive_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dff_drive_seq
//  Purpose  : Drives the d/ck/pr/clr pins of a gate-level NAND D flip-flop
//             with programmable setup, clock-high, clock-low, async-pulse and
//             settle widths, then samples q/nq through synchronisers, checks
//             them against the expected value and returns the result.
//  Ports    : ck, rst_n                      - clock, async active-low reset
//             req_valid/req_ready/req_op/req_d - request channel
//             rsp_valid/rsp_ready/rsp_q/rsp_err - response channel
//             err_cnt                        - saturating error count
//             ff_d, ff_ck, ff_pr, ff_clr     - flip-flop drive pins (pr/clr low-active)
//             ff_q, ff_nq                    - flip-flop outputs (asynchronous)
//  Revision : 1.0 - initial release
// ============================================================================
module dff_drive_seq
    import dff_drive_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int HI_CYC     = 2,
    parameter int LO_CYC     = 2,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   ck,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic                   req_d,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_q,
    output logic                   rsp_err,
    output logic [c_err_cnt_w-1:0] err_cnt,
    output logic                   ff_d,
    output logic                   ff_ck,
    output logic                   ff_pr,
    output logic                   ff_clr,
    input  logic                   ff_q,
    input  logic                   ff_nq
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("SETUP_CYC must be >= 1");
    end
    if (HI_CYC < 1) begin : g_bad_hi
        $error("HI_CYC must be >= 1");
    end
    if (LO_CYC < 1) begin : g_bad_lo
        $error("LO_CYC must be >= 1");
    end
    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("PULSE_CYC must be >= 1");
    end
    if (SETTLE_CYC < 2) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 2");
    end

    // The phase counter holds (width - 1) for the longest timed state.
    localparam int c_max_cyc = max2(max2(max2(SETUP_CYC, HI_CYC), max2(LO_CYC, PULSE_CYC)),
                                    SETTLE_CYC);
    localparam int c_ph_w    = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_ph_w-1:0] c_ld_setup  = c_ph_w'(SETUP_CYC - 1);
    localparam logic [c_ph_w-1:0] c_ld_hi     = c_ph_w'(HI_CYC - 1);
    localparam logic [c_ph_w-1:0] c_ld_lo     = c_ph_w'(LO_CYC - 1);
    localparam logic [c_ph_w-1:0] c_ld_pulse  = c_ph_w'(PULSE_CYC - 1);
    localparam logic [c_ph_w-1:0] c_ld_settle = c_ph_w'(SETTLE_CYC - 1);
    localparam logic [c_ph_w-1:0] c_ph_one    = c_ph_w'(1);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic w_sync_q;
    logic w_sync_nq;

    sync2 u_sync_q (
        .ck    (ck),
        .rst_n (rst_n),
        .din   (ff_q),
        .dout  (w_sync_q)
    );

    sync2 u_sync_nq (
        .ck    (ck),
        .rst_n (rst_n),
        .din   (ff_nq),
        .dout  (w_sync_nq)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_ph_w-1:0]   r_phase;
    logic [c_ph_w-1:0]   w_phase_nxt;
    op_e                 r_op;
    logic                r_exp;

    logic                w_accept;
    op_e                 w_req_op;
    op_e                 w_op_sel;
    logic                w_chk_err;
    logic                w_rsp_load;
    logic                w_rsp_q_nxt;
    logic                w_rsp_err_nxt;

    assign w_req_op = op_e'(req_op);
    assign w_accept = req_valid && (r_state == ST_IDLE);
    // Pin outputs are computed from the next state, so the op that selects
    // pr versus clr must be the one being accepted this cycle if any.
    assign w_op_sel = w_accept ? w_req_op : r_op;

    assign w_chk_err = (w_sync_q == w_sync_nq) | (w_sync_q != r_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (w_req_op)
                        OP_CAPTURE: begin
                            w_state_nxt = ST_SETUP;
                            w_phase_nxt = c_ld_setup;
                        end
                        OP_PRESET, OP_CLEAR: begin
                            w_state_nxt = ST_PULSE;
                            w_phase_nxt = c_ld_pulse;
                        end
                        default: begin
                            w_state_nxt = ST_RESP;
                        end
                    endcase
                end
            end
            ST_SETUP: begin
                if (r_phase == '0) begin
                    w_state_nxt = ST_HIGH;
                    w_phase_nxt = c_ld_hi;
                end else begin
                    w_phase_nxt = r_phase - c_ph_one;
                end
            end
            ST_HIGH: begin
                if (r_phase == '0) begin
                    w_state_nxt = ST_LOW;
                    w_phase_nxt = c_ld_lo;
                end else begin
                    w_phase_nxt = r_phase - c_ph_one;
                end
            end
            ST_LOW, ST_PULSE: begin
                if (r_phase == '0) begin
                    w_state_nxt = ST_SETTLE;
                    w_phase_nxt = c_ld_settle;
                end else begin
                    w_phase_nxt = r_phase - c_ph_one;
                end
            end
            ST_SETTLE: begin
                if (r_phase == '0) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_phase_nxt = r_phase - c_ph_one;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The check result is registered on the edge entering CHECK so that
    // rsp_q/rsp_err/err_cnt are visible during the CHECK cycle itself. A
    // reserved op loads its (always-failing) result on the accept edge.
    always_comb begin
        w_rsp_load    = 1'b0;
        w_rsp_q_nxt   = rsp_q;
        w_rsp_err_nxt = rsp_err;
        if (w_accept && (w_req_op == OP_RSVD)) begin
            w_rsp_load    = 1'b1;
            w_rsp_q_nxt   = w_sync_q;
            w_rsp_err_nxt = 1'b1;
        end else if ((r_state == ST_SETTLE) && (w_state_nxt == ST_CHECK)) begin
            w_rsp_load    = 1'b1;
            w_rsp_q_nxt   = w_sync_q;
            w_rsp_err_nxt = w_chk_err;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_op      <= OP_CAPTURE;
            r_exp     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
            err_cnt   <= '0;
            ff_d      <= 1'b0;
            ff_ck     <= 1'b0;
            ff_pr     <= 1'b1;
            ff_clr    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            req_ready <= (w_state_nxt == ST_IDLE);
            rsp_valid <= (w_state_nxt == ST_RESP);
            ff_ck     <= (w_state_nxt == ST_HIGH);
            ff_pr     <= !((w_state_nxt == ST_PULSE) && (w_op_sel == OP_PRESET));
            ff_clr    <= !((w_state_nxt == ST_PULSE) && (w_op_sel == OP_CLEAR));

            if (w_accept) begin
                r_op <= w_req_op;
                case (w_req_op)
                    OP_CAPTURE: r_exp <= req_d;
                    OP_PRESET:  r_exp <= 1'b1;
                    default:    r_exp <= 1'b0;
                endcase
                // d only moves on a capture; preset/clear leave it alone.
                if (w_req_op == OP_CAPTURE) begin
                    ff_d <= req_d;
                end
            end

            rsp_q   <= w_rsp_q_nxt;
            rsp_err <= w_rsp_err_nxt;
            if (w_rsp_load && w_rsp_err_nxt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + c_err_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dff_drive_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_drive_seq
//  Purpose  : Self-checking bench for dff_drive_seq driving a behavioural
//             flat D flip-flop with optional faults on q/nq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dff_drive_seq;
    import dff_drive_pkg::*;

    localparam int SETUP_CYC  = 1;
    localparam int HI_CYC     = 2;
    localparam int LO_CYC     = 2;
    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 2;

    logic       ck;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic       req_d;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_q;
    logic       rsp_err;
    logic [7:0] err_cnt;
    logic       ff_d;
    logic       ff_ck;
    logic       ff_pr;
    logic       ff_clr;
    logic       ff_q;
    logic       ff_nq;

    dff_drive_seq #(
        .SETUP_CYC  (SETUP_CYC),
        .HI_CYC     (HI_CYC),
        .LO_CYC     (LO_CYC),
        .PULSE_CYC  (PULSE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt),
        .ff_d      (ff_d),
        .ff_ck     (ff_ck),
        .ff_pr     (ff_pr),
        .ff_clr    (ff_clr),
        .ff_q      (ff_q),
        .ff_nq     (ff_nq)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Behavioural flat D flip-flop with async low-active preset/clear.
    logic flop_q = 1'b0;
    always @(posedge ff_ck or negedge ff_pr or negedge ff_clr) begin
        if (!ff_pr)       flop_q <= 1'b1;
        else if (!ff_clr) flop_q <= 1'b0;
        else              flop_q <= ff_d;
    end

    // fault: 0 none, 1 q=nq=1, 2 q=nq=0, 3 q/nq inverted
    int fault = 0;
    always_comb begin
        case (fault)
            1:       begin ff_q = 1'b1;    ff_nq = 1'b1;    end
            2:       begin ff_q = 1'b0;    ff_nq = 1'b0;    end
            3:       begin ff_q = ~flop_q; ff_nq = flop_q;  end
            default: begin ff_q = flop_q;  ff_nq = ~flop_q; end
        endcase
    end

    // Pin activity monitor (cumulative, sampled on falling ck).
    int   m_ck_hi = 0, m_ck_rise = 0, m_pr_lo = 0, m_clr_lo = 0, m_both_lo = 0, m_tog = 0;
    logic m_prev_ck = 1'b0;
    logic m_d_at_rise = 1'b0;
    logic [3:0] m_prev_pins = 4'b0011;
    always @(negedge ck) begin
        if (ff_ck) m_ck_hi++;
        if (ff_ck && !m_prev_ck) begin
            m_ck_rise++;
            m_d_at_rise = ff_d;
        end
        if (!ff_pr)  m_pr_lo++;
        if (!ff_clr) m_clr_lo++;
        if (!ff_pr && !ff_clr) m_both_lo++;
        if ({ff_d, ff_ck, ff_pr, ff_clr} != m_prev_pins) m_tog++;
        m_prev_pins = {ff_d, ff_ck, ff_pr, ff_clr};
        m_prev_ck   = ff_ck;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: flip-flop content and error count.
    int ref_q   = 0;
    int ref_cnt = 0;

    task automatic run_op(input int op, input int d, input int hold);
        int  exp_v, exp_lat, oq, onq, e_err, lat, prev_cnt;
        int  s_hi, s_rise, s_pr, s_clr, s_tog;
        bit  got;
        exp_v   = 0;
        exp_lat = 1;
        case (op)
            0: begin exp_v = d; ref_q = d; exp_lat = SETUP_CYC + HI_CYC + LO_CYC + SETTLE_CYC + 1; end
            1: begin exp_v = 1; ref_q = 1; exp_lat = PULSE_CYC + SETTLE_CYC + 1; end
            2: begin exp_v = 0; ref_q = 0; exp_lat = PULSE_CYC + SETTLE_CYC + 1; end
            default: begin exp_v = 0; exp_lat = 1; end
        endcase
        case (fault)
            1:       begin oq = 1;         onq = 1;         end
            2:       begin oq = 0;         onq = 0;         end
            3:       begin oq = 1 - ref_q; onq = ref_q;     end
            default: begin oq = ref_q;     onq = 1 - ref_q; end
        endcase
        e_err = ((op == 3) || (oq == onq) || (oq != exp_v)) ? 1 : 0;
        if (e_err == 1 && ref_cnt < 255) ref_cnt++;

        // idle gap lets the synchronisers settle after any fault change
        repeat (3) @(negedge ck);
        chk("req_ready_idle", req_ready, 1);
        s_hi = m_ck_hi; s_rise = m_ck_rise; s_pr = m_pr_lo; s_clr = m_clr_lo; s_tog = m_tog;
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_d     = d[0];
        @(posedge ck);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_d     = 1'($urandom);

        lat = 0;
        got = 0;
        prev_cnt = int'(err_cnt);
        while (!got && lat < 50) begin
            prev_cnt = int'(err_cnt);
            @(posedge ck);
            #1;
            lat++;
            if (rsp_valid) got = 1;
        end
        chk("rsp_timeout", 32'(got), 1);
        chk("latency", lat, exp_lat);
        chk("rsp_q", rsp_q, oq);
        chk("rsp_err", rsp_err, e_err);
        chk("err_cnt", err_cnt, ref_cnt);
        chk("req_ready_busy", req_ready, 0);
        if (op != 3) chk("err_cnt_in_check", prev_cnt, ref_cnt);

        for (int i = 0; i < hold; i++) begin
            @(posedge ck);
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_q", rsp_q, oq);
            chk("hold_err", rsp_err, e_err);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge ck);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("back_idle", req_ready, 1);

        case (op)
            0: begin
                chk("cap_ck_rise", m_ck_rise - s_rise, 1);
                chk("cap_ck_hi", m_ck_hi - s_hi, HI_CYC);
                chk("cap_d", m_d_at_rise, d);
                chk("cap_no_pr_clr", (m_pr_lo - s_pr) + (m_clr_lo - s_clr), 0);
            end
            1: begin
                chk("pre_pr_lo", m_pr_lo - s_pr, PULSE_CYC);
                chk("pre_no_clr_ck", (m_clr_lo - s_clr) + (m_ck_hi - s_hi), 0);
            end
            2: begin
                chk("clr_clr_lo", m_clr_lo - s_clr, PULSE_CYC);
                chk("clr_no_pr_ck", (m_pr_lo - s_pr) + (m_ck_hi - s_hi), 0);
            end
            default: begin
                chk("rsvd_no_toggle", m_tog - s_tog, 0);
            end
        endcase
    endtask

    task automatic reset_in_high();
        int  n, d;
        bit  saw;
        d = int'($urandom_range(0, 1));
        repeat (3) @(negedge ck);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_d     = d[0];
        @(posedge ck);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!ff_ck && n < 20) begin
            @(posedge ck);
            #1;
            n++;
        end
        chk("reached_high", ff_ck, 1);
        ref_q = d;      // the rising ck already captured d
        #2;
        rst_n = 1'b0;
        #1;
        ref_cnt = 0;
        chk("rst_ck", ff_ck, 0);
        chk("rst_pr", ff_pr, 1);
        chk("rst_clr", ff_clr, 1);
        chk("rst_ready", req_ready, 1);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_valid", rsp_valid, 0);
        @(negedge ck);
        rst_n = 1'b1;
        saw = 0;
        repeat (15) begin
            @(negedge ck);
            if (rsp_valid) saw = 1;
        end
        chk("no_rsp_after_rst", 32'(saw), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_d     = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("reset_ready", req_ready, 1);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_q", rsp_q, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_cnt", err_cnt, 0);
        chk("reset_pins", {ff_d, ff_ck, ff_pr, ff_clr}, 4'b0011);
        rst_n = 1'b1;

        // directed
        run_op(1, 0, 0);
        run_op(0, 0, 0);
        run_op(0, 1, 0);
        fault = 1;
        run_op(2, 0, 0);
        fault = 0;
        run_op(0, 1, 0);
        run_op(3, 0, 0);
        run_op(1, 0, 10);

        // randomized
        for (int i = 0; i < 40; i++) begin
            fault = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end
        fault = 0;
        run_op(3, 0, 0);

        reset_in_high();

        // saturation of err_cnt
        for (int i = 0; i < 258; i++) begin
            run_op(3, 0, 0);
        end
        run_op(0, 1, 0);

        chk("pr_clr_never_both_low", m_both_lo, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
